// File: rtl/button_debounce.sv
// Button conditioner: two-flop synchroniser, per-button stability counter, level plus press/release pulses.
// Define BUTTON_EVENT_LATCH_EN to add sticky press events (events/event_clear) and an irq line.
module button_debounce #(
    parameter int BUTTONCOUNT     = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_raw,
    output logic [BUTTONCOUNT-1:0] buttons,
    output logic [BUTTONCOUNT-1:0] pressed,
    output logic [BUTTONCOUNT-1:0] released
`ifdef BUTTON_EVENT_LATCH_EN
    ,
    input  logic [BUTTONCOUNT-1:0] event_clear,
    output logic [BUTTONCOUNT-1:0] events,
    output logic                   irq
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BUTTONCOUNT-1:0] IDLE_RAW = {BUTTONCOUNT{ACTIVE_LOW}};

    typedef enum logic {STABLE, PENDING} state_t;

    logic [BUTTONCOUNT-1:0] sync1_reg;
    logic [BUTTONCOUNT-1:0] sync2_reg;
    logic [BUTTONCOUNT-1:0] level;

    // Synchroniser resets to the raw "released" level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= IDLE_RAW;
            sync2_reg <= IDLE_RAW;
        end else begin
            sync1_reg <= buttons_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign level = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

    for (genvar gi = 0; gi < BUTTONCOUNT; gi++) begin : g_btn
        state_t        state_reg;
        logic [CW-1:0] count_reg;
        logic          btn_reg;
        logic          prs_reg;
        logic          rel_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_reg <= STABLE;
                count_reg <= '0;
                btn_reg   <= 1'b0;
                prs_reg   <= 1'b0;
                rel_reg   <= 1'b0;
            end else begin
                prs_reg <= 1'b0;
                rel_reg <= 1'b0;
                case (state_reg)
                    STABLE: begin
                        if (level[gi] != btn_reg) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                btn_reg <= level[gi];
                                prs_reg <= level[gi];
                                rel_reg <= ~level[gi];
                            end else begin
                                state_reg <= PENDING;
                                count_reg <= CW'(1);
                            end
                        end
                    end
                    PENDING: begin
                        if (level[gi] == btn_reg) begin
                            state_reg <= STABLE;
                            count_reg <= '0;
                        end else if (count_reg == LAST_COUNT) begin
                            // This mismatch is the final one needed: accept the new level.
                            state_reg <= STABLE;
                            count_reg <= '0;
                            btn_reg   <= level[gi];
                            prs_reg   <= level[gi];
                            rel_reg   <= ~level[gi];
                        end else begin
                            count_reg <= count_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_reg <= STABLE;
                        count_reg <= '0;
                    end
                endcase
            end
        end

        assign buttons[gi]  = btn_reg;
        assign pressed[gi]  = prs_reg;
        assign released[gi] = rel_reg;
    end

`ifdef BUTTON_EVENT_LATCH_EN
    logic [BUTTONCOUNT-1:0] events_reg;
    logic                   irq_reg;

    // Setting from the registered pulse lets a press win over a clear issued while the pulse is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            events_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            events_reg <= (events_reg & ~event_clear) | pressed;
            irq_reg    <= |events_reg;
        end
    end

    assign events = events_reg;
    assign irq    = irq_reg;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: window-based reference model checked every cycle, plus literal expectations.
module tb_button_debounce;

    localparam int NB = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] raw_a, raw_b;
    logic [NB-1:0] btn_a, prs_a, rel_a;
    logic [NB-1:0] btn_b, prs_b, rel_b;
`ifdef BUTTON_EVENT_LATCH_EN
    logic [NB-1:0] clr_a, clr_b, ev_a, ev_b;
    logic          irq_a, irq_b;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    button_debounce #(.BUTTONCOUNT(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .buttons_raw(raw_a),
        .buttons(btn_a), .pressed(prs_a), .released(rel_a)
`ifdef BUTTON_EVENT_LATCH_EN
        , .event_clear(clr_a), .events(ev_a), .irq(irq_a)
`endif
    );

    button_debounce #(.BUTTONCOUNT(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .buttons_raw(raw_b),
        .buttons(btn_b), .pressed(prs_b), .released(rel_b)
`ifdef BUTTON_EVENT_LATCH_EN
        , .event_clear(clr_b), .events(ev_b), .irq(irq_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a change is accepted once the last DC synchronised samples all differ from the level.
    logic [NB-1:0] m_btn [2];
    logic [NB-1:0] m_prs [2];
    logic [NB-1:0] m_rel [2];
    logic [NB-1:0] p1 [2];
    logic [NB-1:0] p2 [2];
    logic [15:0]   hist [2][NB];
    logic [NB-1:0] m_ev;
    logic          m_irq;
    logic          started = 1'b0;

    initial begin
        logic [NB-1:0] rc;
        logic          acc;
        m_ev  = '0;
        m_irq = 1'b0;
        forever begin
            @(posedge clk);
            for (int n = 0; n < 2; n++) begin
                rc = (n == 0) ? raw_a : ~raw_b;
                if (reset) begin
                    p1[n] = '0; p2[n] = '0;
                    m_btn[n] = '0; m_prs[n] = '0; m_rel[n] = '0;
                    for (int b = 0; b < NB; b++) hist[n][b] = '0;
                    if (n == 0) begin m_ev = '0; m_irq = 1'b0; end
                end else begin
`ifdef BUTTON_EVENT_LATCH_EN
                    if (n == 0) begin
                        m_irq = |m_ev;
                        m_ev  = (m_ev & ~clr_a) | m_prs[0];
                    end
`endif
                    m_prs[n] = '0;
                    m_rel[n] = '0;
                    for (int b = 0; b < NB; b++) begin
                        hist[n][b] = {hist[n][b][14:0], p2[n][b]};
                        acc = 1'b1;
                        for (int k = 0; k < DC; k++)
                            if (hist[n][b][k] == m_btn[n][b]) acc = 1'b0;
                        if (acc) begin
                            m_btn[n][b] = ~m_btn[n][b];
                            if (m_btn[n][b]) m_prs[n][b] = 1'b1;
                            else             m_rel[n][b] = 1'b1;
                        end
                    end
                    p2[n] = p1[n];
                    p1[n] = rc;
                end
            end
            started = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("a_buttons",  btn_a, m_btn[0]);
                check("a_pressed",  prs_a, m_prs[0]);
                check("a_released", rel_a, m_rel[0]);
                check("b_buttons",  btn_b, m_btn[1]);
                check("b_pressed",  prs_b, m_prs[1]);
                check("b_released", rel_b, m_rel[1]);
`ifdef BUTTON_EVENT_LATCH_EN
                check("a_events", ev_a, m_ev);
                check("a_irq",    irq_a, m_irq);
                check("b_events", ev_b, 4'b0000);
                check("b_irq",    irq_b, 1'b0);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        raw_a = 4'b0001;
        raw_b = 4'b1111;
`ifdef BUTTON_EVENT_LATCH_EN
        clr_a = '0;
        clr_b = '0;
`endif
        // Reset held for 3 edges with a pressed pin
        for (int i = 0; i < 3; i++) begin
            edges(1);
            check("rst_buttons", btn_a, 4'b0000);
            check("rst_pressed", prs_a, 4'b0000);
            check("rst_released", rel_a, 4'b0000);
        end
        reset = 1'b0;
        edges(5);
        check("t1_buttons_e5", btn_a, 4'b0000);
        edges(1);
        check("t1_buttons_e6", btn_a, 4'b0001);
        check("t1_pressed_e6", prs_a, 4'b0001);
        check("t1_released_e6", rel_a, 4'b0000);
        edges(1);
        check("t1_pressed_e7", prs_a, 4'b0000);

        // Short pulse on bit 1 is rejected
        raw_a = 4'b0011;
        edges(3);
        raw_a = 4'b0001;
        edges(8);
        check("t2_buttons", btn_a, 4'b0001);

        // Bounce on bit 2, then steady high
        raw_a = 4'b0101; edges(1);
        raw_a = 4'b0001; edges(1);
        raw_a = 4'b0101; edges(1);
        raw_a = 4'b0001; edges(1);
        raw_a = 4'b0101;
        edges(5);
        check("t3_pressed_e5", prs_a, 4'b0000);
        edges(1);
        check("t3_pressed_e6", prs_a, 4'b0100);
        check("t3_buttons_e6", btn_a, 4'b0101);
        edges(1);
        check("t3_pressed_e7", prs_a, 4'b0000);

        // Active-low instance: press and release bit 3
        raw_b = 4'b0111;
        edges(6);
        check("t4_buttons_press", btn_b, 4'b1000);
        check("t4_pressed", prs_b, 4'b1000);
        raw_b = 4'b1111;
        edges(5);
        check("t4_released_e5", rel_b, 4'b0000);
        edges(1);
        check("t4_released_e6", rel_b, 4'b1000);
        check("t4_buttons_rel", btn_b, 4'b0000);

        // Reset in the middle of a count on bit 0
        raw_a = 4'b0000;
        edges(8);
        check("t5_all_released", btn_a, 4'b0000);
        raw_a = 4'b0001;
        edges(4);
        reset = 1'b1;
        edges(1);
        check("t5_buttons_rst", btn_a, 4'b0000);
        reset = 1'b0;
        edges(5);
        check("t5_buttons_e5", btn_a, 4'b0000);
        edges(1);
        check("t5_pressed_e6", prs_a, 4'b0001);
        check("t5_buttons_e6", btn_a, 4'b0001);

`ifdef BUTTON_EVENT_LATCH_EN
        // Sticky events, clear, and set-wins-over-clear
        raw_a = 4'b1001;
        edges(6);
        check("t6_pressed3", prs_a, 4'b1000);
        edges(1);
        check("t6_events", ev_a, 4'b1001);
        edges(1);
        check("t6_irq", irq_a, 1'b1);
        clr_a = 4'b0001;
        edges(1);
        clr_a = 4'b0000;
        check("t6_clear0", ev_a, 4'b1000);
        raw_a = 4'b0001;
        edges(8);
        raw_a = 4'b1001;
        edges(6);
        check("t6_pressed3_again", prs_a, 4'b1000);
        clr_a = 4'b1000;
        edges(1);
        clr_a = 4'b0000;
        check("t6_set_wins", ev_a, 4'b1000);
        edges(2);
        check("t6_set_held", ev_a, 4'b1000);
        clr_a = 4'b1000;
        edges(1);
        clr_a = 4'b0000;
        check("t6_clear3", ev_a, 4'b0000);
        edges(1);
        check("t6_irq_low", irq_a, 1'b0);
`endif

        edges(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
